led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer_if.sv | 26 ++
 rtl/led_sequencer.sv | 175 +++++++++++++++++
 tb/tb_led_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/led_sequencer_if.sv
// Command handshake between a requester and the LED sequencer.
interface led_sequencer_if;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned RATE_W = 4;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [MODE_W-1:0] cmd_mode;
  logic [RATE_W-1:0] cmd_rate;

  // Requester side
  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_rate,
    input  cmd_ready
  );

  // Sequencer side
  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_rate,
    output cmd_ready
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled step strobe drives OFF/SCAN/COUNT/BLINK
// patterns; new commands are parked until the next unpaused step.
module led_sequencer #(
  parameter int unsigned PRESCALE_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_sequencer_if.slave        cmd,
  input  logic                  pause,
  output logic [7:0]            leds,
  output logic                  busy,
  output logic                  tick
);

  localparam int unsigned PW     = PRESCALE_WIDTH;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned RATE_W = 4;

  localparam logic [PW-1:0]    CNT_ONE  = PW'(1);
  localparam logic [PW-1:0]    CNT_ONES = '1;
  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  mode_e               pmode_q, pmode_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic [RATE_W-1:0]   prate_q, prate_d;
  dir_e                dir_q, dir_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic                tick_q, tick_d;
  logic [PW-1:0]       cnt_q;

  logic [PW-1:0]       mask_c;
  logic                raw_tick_c;
  logic                step_c;

  // Pattern loaded when a command takes effect.
  function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
    logic [LED_W-1:0] p;
    p = '0;
    case (m)
      MODE_OFF:   p = '0;
      MODE_SCAN:  p = LED_ONE;
      MODE_COUNT: p = '0;
      MODE_BLINK: p = '1;
    endcase
    return p;
  endfunction

  // Free-running prescaler; never frozen by pause or commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Step strobe: counter bits under the rate mask all set (mask 0 -> every cycle).
  always_comb begin
    mask_c = '0;
    if (32'(rate_q) < PW) begin
      mask_c = CNT_ONES >> rate_q;
    end
    raw_tick_c = ((cnt_q & mask_c) == mask_c);
    step_c     = raw_tick_c & ~pause;
  end

  // Controller, pattern and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      mode_q  <= MODE_SCAN;
      pmode_q <= MODE_OFF;
      rate_q  <= '0;
      prate_q <= '0;
      dir_q   <= DIR_LEFT;
      leds_q  <= LED_ONE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pmode_q <= pmode_d;
      rate_q  <= rate_d;
      prate_q <= prate_d;
      dir_q   <= dir_d;
      leds_q  <= leds_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state: step the active pattern in RUN, park commands, apply on a step in PENDING.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pmode_d = pmode_q;
    rate_d  = rate_q;
    prate_d = prate_q;
    dir_d   = dir_q;
    leds_d  = leds_q;
    tick_d  = step_c;

    case (state_q)
      ST_RUN: begin
        if (step_c) begin
          case (mode_q)
            MODE_OFF: begin
              leds_d = '0;
            end
            MODE_SCAN: begin
              // End LED dwells one extra step while the direction flips.
              if (dir_q == DIR_LEFT) begin
                if (leds_q[LED_W-1]) begin
                  dir_d = DIR_RIGHT;
                end else begin
                  leds_d = leds_q << 1;
                end
              end else begin
                if (leds_q[0]) begin
                  dir_d = DIR_LEFT;
                end else begin
                  leds_d = leds_q >> 1;
                end
              end
            end
            MODE_COUNT: begin
              leds_d = leds_q + LED_ONE;
            end
            MODE_BLINK: begin
              leds_d = ~leds_q;
            end
          endcase
        end
        // Acceptance is not gated by pause; the step above is unaffected.
        if (cmd.cmd_valid) begin
          pmode_d = mode_e'(cmd.cmd_mode);
          prate_d = cmd.cmd_rate;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (step_c) begin
          mode_d  = pmode_q;
          rate_d  = prate_q;
          leds_d  = init_pattern(pmode_q);
          dir_d   = DIR_LEFT;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  assign leds          = leds_q;
  assign tick          = tick_q;
  assign busy          = (state_q == ST_PENDING);
  assign cmd.cmd_ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer at PRESCALE_WIDTH=4.
module tb_led_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pause;
  logic [7:0] leds;
  logic       busy;
  logic       tick;

  led_sequencer_if cmd_if ();

  led_sequencer #(.PRESCALE_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd_if),
    .pause (pause),
    .leds  (leds),
    .busy  (busy),
    .tick  (tick)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  logic [7:0]  sb_q[$];
  int          cyc = 0;
  int          last_tick = 0;
  int          exp_period = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] v);
    sb_q.push_back(v);
  endtask

  // Bounded wait until the scoreboard holds at most 'target' entries.
  task automatic wait_size(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (sb_q.size() > target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(sb_q.size()), 32'(target));
  endtask

  task automatic send(input logic [1:0] mode, input logic [3:0] rate);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = mode;
    cmd_if.cmd_rate  = rate;
  endtask

  // Monitor: on every tick pop the expected pattern and check the tick spacing.
  always @(negedge clk) begin
    cyc++;
    if (tick === 1'b1) begin
      if (exp_period != 0) chk("period", 32'(cyc - last_tick), 32'(exp_period));
      last_tick = cyc;
      if (sb_q.size() > 0) chk("leds", 32'(leds), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] scan_seq [17];
    int n;
    scan_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01, 8'h02};
    rst_n = 1'b0;
    pause = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'd0;
    cmd_if.cmd_rate  = 4'd0;
    repeat (3) @(negedge clk);
    #1;

    // Reset state
    chk("rst_leds", 32'(leds), 32'h01);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("rst_tick", 32'(tick), 32'h0);

    // Default SCAN, rate 0: step every 16 cycles with end dwell
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) push(scan_seq[i]);
    wait_size(16, 40, "scan_first");
    exp_period = 16;
    wait_size(0, 300, "scan_drain");

    // COUNT rate 2: busy until the old-period tick, then 00,01,... wrapping
    exp_period = 0;
    push(8'h00);
    for (int i = 1; i < 256; i++) push(8'(i));
    push(8'h00);
    send(2'd2, 4'd2);
    @(negedge clk); #1;
    chk("cnt_busy", 32'(busy), 32'h1);
    chk("cnt_ready", 32'(cmd_if.cmd_ready), 32'h0);
    cmd_if.cmd_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("cnt_busy_len", 32'(n), 32'd15);
    chk("cnt_ready_back", 32'(cmd_if.cmd_ready), 32'h1);
    exp_period = 4;
    wait_size(0, 1100, "cnt_drain");

    // BLINK rate 4: mask 0, tick every cycle, alternating FF/00
    exp_period = 0;
    for (int i = 0; i < 10; i++) push((i % 2 == 0) ? 8'hFF : 8'h00);
    send(2'd3, 4'd4);
    @(negedge clk); #1;
    chk("blink_busy", 32'(busy), 32'h1);
    cmd_if.cmd_valid = 1'b0;
    wait_size(9, 20, "blink_apply");
    exp_period = 1;
    wait_size(0, 20, "blink_drain");

    // Pause 40 cycles with a SCAN rate 3 command accepted mid-pause
    exp_period = 0;
    pause = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      chk("pause_tick", 32'(tick), 32'h0);
      chk("pause_leds", 32'(leds), 32'h00);
      if (i == 19) send(2'd1, 4'd3);
      if (i == 20) begin
        chk("pause_busy", 32'(busy), 32'h1);
        chk("pause_ready", 32'(cmd_if.cmd_ready), 32'h0);
        cmd_if.cmd_valid = 1'b0;
      end
    end
    chk("pause_busy_end", 32'(busy), 32'h1);
    push(8'h01); push(8'h02); push(8'h04); push(8'h08);
    pause = 1'b0;
    @(negedge clk); #1;
    chk("unpause_apply", 32'(busy), 32'h0);
    wait_size(2, 20, "scan2_first");
    exp_period = 2;
    wait_size(0, 20, "scan2_drain");

    // Command accepted on a raw-tick cycle: step now, apply on the next tick
    exp_period = 0;
    push(8'h10); push(8'h00); push(8'h01); push(8'h02);
    @(negedge clk); #1;
    send(2'd2, 4'd1);
    @(negedge clk); #1;
    chk("coinc_busy", 32'(busy), 32'h1);
    chk("coinc_tick", 32'(tick), 32'h1);
    cmd_if.cmd_valid = 1'b0;
    wait_size(1, 40, "coinc_apply");
    exp_period = 8;
    wait_size(0, 20, "coinc_drain");

    // Async reset while PENDING discards the parked command
    exp_period = 0;
    send(2'd3, 4'd0);
    @(negedge clk); #1;
    chk("rst2_busy_pre", 32'(busy), 32'h1);
    cmd_if.cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_leds", 32'(leds), 32'h01);
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("rst2_tick", 32'(tick), 32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    push(8'h02); push(8'h04);
    wait_size(1, 40, "rst2_first");
    exp_period = 16;
    wait_size(0, 40, "rst2_drain");
    chk("rst2_busy_end", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
